// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-unit arbiter/controller: op codes, FSM states,
// right-shift-type selects and the out-of-range amount helpers.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_BYPASS = 2'b10,
    ST_RESP   = 2'b11
  } ctrl_state_e;

  localparam logic [1:0] RSC_NONE   = 2'b00;
  localparam logic [1:0] RSC_LOGIC  = 2'b01;
  localparam logic [1:0] RSC_ARITH  = 2'b10;
  localparam logic [1:0] RSC_ROTATE = 2'b11;

  function automatic logic [1:0] op_to_rsc(input shift_op_e op);
    logic [1:0] rsc;
    case (op)
      OP_SRL:  rsc = RSC_LOGIC;
      OP_SRA:  rsc = RSC_ARITH;
      OP_ROR:  rsc = RSC_ROTATE;
      default: rsc = RSC_NONE;
    endcase
    return rsc;
  endfunction

  // Rotates wrap modulo 8, so only the true shifts can run off the end.
  function automatic logic amt_out_of_range(input shift_op_e op, input logic [7:0] amt);
    return (op != OP_ROR) && (amt[7:3] != 5'd0);
  endfunction

  function automatic logic [7:0] bypass_result(input shift_op_e op, input logic sign);
    return (op == OP_SRA) ? {8{sign}} : 8'h00;
  endfunction

endpackage

// File: rtl/shift_rr_arbiter.sv
// Two-way grant logic for the shift unit: round-robin or fixed req0 priority.
// The pointer remembers the last accepted requester and moves only on accept.
module shift_rr_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  input  logic accept,
  output logic grant_vld,
  output logic grant_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    if (valid0 && valid1) begin
      grant_id = (PRIORITY_MODE != 0) ? 1'b0 : ~last_q;
    end else begin
      grant_id = valid1;
    end
    grant_vld = enable && (valid0 || valid1);
    last_d    = accept ? grant_id : last_q;
  end

  // Reset value 1 makes req0 the winner of the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/shifter_arbiter_ctrl.sv
// Shares one 8-bit shift unit between two requesters: arbitrates, registers
// operands, holds the unit inputs through a settle window and returns a tagged result.
module shifter_arbiter_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [1:0] REQ0_OP,
  input  logic [7:0] REQ0_DATA,
  input  logic [7:0] REQ0_AMT,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [1:0] REQ1_OP,
  input  logic [7:0] REQ1_DATA,
  input  logic [7:0] REQ1_AMT,
  output logic       RESP_VALID,
  output logic       RESP_ID,
  output logic [7:0] RESP_RESULT,
  output logic       BUSY,
  output logic [7:0] SH_DATA,
  output logic [7:0] SH_AMT,
  output logic       SH_LEFT,
  output logic [1:0] SH_RSC,
  input  logic [7:0] SH_RESULT
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shift_op_e  op_q, op_d;
  logic       sign_q, sign_d;
  logic       id_q, id_d;
  logic       resp_valid_q, resp_valid_d;
  logic [7:0] resp_result_q, resp_result_d;
  logic       busy_q, busy_d;
  logic [7:0] sh_data_q, sh_data_d;
  logic [7:0] sh_amt_q, sh_amt_d;
  logic       sh_left_q, sh_left_d;
  logic [1:0] sh_rsc_q, sh_rsc_d;

  logic       grant_vld;
  logic       grant_id;
  logic       arb_enable;
  shift_op_e  sel_op;
  logic [7:0] sel_data;
  logic [7:0] sel_amt;

  // READY must stay low while reset is asserted, even though state reads IDLE.
  assign arb_enable = (state_q == ST_IDLE) && RESET;

  shift_rr_arbiter #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_arb (
    .clk      (CLK),
    .rst_n    (RESET),
    .valid0   (REQ0_VALID),
    .valid1   (REQ1_VALID),
    .enable   (arb_enable),
    .accept   (grant_vld),
    .grant_vld(grant_vld),
    .grant_id (grant_id)
  );

  assign REQ0_READY = grant_vld && !grant_id;
  assign REQ1_READY = grant_vld && grant_id;

  assign sel_op   = shift_op_e'(grant_id ? REQ1_OP : REQ0_OP);
  assign sel_data = grant_id ? REQ1_DATA : REQ0_DATA;
  assign sel_amt  = grant_id ? REQ1_AMT : REQ0_AMT;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    sign_d        = sign_q;
    id_d          = id_q;
    resp_valid_d  = 1'b0;
    resp_result_d = resp_result_q;
    busy_d        = busy_q;
    sh_data_d     = sh_data_q;
    sh_amt_d      = sh_amt_q;
    sh_left_d     = sh_left_q;
    sh_rsc_d      = sh_rsc_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          op_d   = sel_op;
          sign_d = sel_data[7];
          id_d   = grant_id;
          busy_d = 1'b1;
          if (amt_out_of_range(sel_op, sel_amt)) begin
            state_d = ST_BYPASS;
          end else begin
            // Shift unit inputs change only here, so they are stable for all of WAIT.
            state_d   = ST_WAIT;
            cnt_d     = CNT_W'(SETTLE_CYCLES);
            sh_data_d = sel_data;
            sh_amt_d  = {5'b0, sel_amt[2:0]};
            sh_left_d = (sel_op == OP_SLL);
            sh_rsc_d  = op_to_rsc(sel_op);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          resp_result_d = SH_RESULT;
          resp_valid_d  = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BYPASS: begin
        resp_result_d = bypass_result(op_q, sign_q);
        resp_valid_d  = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= OP_SLL;
      sign_q        <= 1'b0;
      id_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= 8'h00;
      busy_q        <= 1'b0;
      sh_data_q     <= 8'h00;
      sh_amt_q      <= 8'h00;
      sh_left_q     <= 1'b0;
      sh_rsc_q      <= RSC_NONE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      sign_q        <= sign_d;
      id_q          <= id_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      busy_q        <= busy_d;
      sh_data_q     <= sh_data_d;
      sh_amt_q      <= sh_amt_d;
      sh_left_q     <= sh_left_d;
      sh_rsc_q      <= sh_rsc_d;
    end
  end

  assign RESP_VALID  = resp_valid_q;
  assign RESP_ID     = id_q;
  assign RESP_RESULT = resp_result_q;
  assign BUSY        = busy_q;
  assign SH_DATA     = sh_data_q;
  assign SH_AMT      = sh_amt_q;
  assign SH_LEFT     = sh_left_q;
  assign SH_RSC      = sh_rsc_q;

endmodule
